// File: rtl/ext_bus_target_pkg.sv
// Shared types and constants for the external-bus responder: FSM states,
// strobe idle levels and the synchronised pin bundles.
package ext_bus_target_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int AD_W       = 16;
  localparam int HI_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ARMED,
    ST_RD_REQ,
    ST_RD_DRIVE,
    ST_WR_WAIT,
    ST_WR_REQ,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic ale_n;
    logic oe_n;
    logic we_n;
  } strobes_t;

  typedef struct packed {
    logic            pio;
    logic [HI_W-1:0] adr_hi;
    logic [AD_W-1:0] ad;
  } bus_data_t;

  localparam strobes_t STROBES_IDLE = '{ale_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

endpackage

// File: rtl/ext_bus_target_if.sv
// Pin-side multiplexed bus plus the internal single-request target port.
interface ext_bus_target_if
  import ext_bus_target_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [AD_W-1:0]   ad_in;
  logic [AD_W-1:0]   ad_out;
  logic              ad_oe;
  logic [HI_W-1:0]   adr_hi;
  logic              pio;
  logic              ale_n;
  logic              oe_n;
  logic              we_n;
  logic              tgt_req;
  logic              tgt_we;
  logic              tgt_io;
  logic [ADDR_W-1:0] tgt_adr;
  logic [AD_W-1:0]   tgt_wdata;
  logic [AD_W-1:0]   tgt_rdata;
  logic              tgt_ack;
  logic              err;

  modport slave (
    input  ad_in, adr_hi, pio, ale_n, oe_n, we_n, tgt_rdata, tgt_ack,
    output ad_out, ad_oe, tgt_req, tgt_we, tgt_io, tgt_adr, tgt_wdata, err
  );

  modport master (
    output ad_in, adr_hi, pio, ale_n, oe_n, we_n, tgt_rdata, tgt_ack,
    input  ad_out, ad_oe, tgt_req, tgt_we, tgt_io, tgt_adr, tgt_wdata, err
  );
endinterface

// File: rtl/ext_bus_target_bus_sync.sv
// N-stage vector synchronizer with a configurable reset value.
module ext_bus_target_bus_sync #(
  parameter int           W       = 1,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] stg;

  // NOTE: sequential state uses non-blocking assignments only, and every stage
  // resets to the bus idle level so no phantom edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg <= {STAGES{RST_VAL}};
    else        stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/ext_bus_target.sv
// Responder for the CPU's multiplexed pin bus: latches the 20-bit address,
// issues one internal request per strobe and drives read data back onto AD.
module ext_bus_target
  import ext_bus_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ext_bus_target_if.slave   bus
);

  strobes_t        strb_s;
  bus_data_t       data_s;
  state_t          state_q, state_d;
  logic            oe_p, we_p;
  logic [AD_W-1:0] ad_d;
  logic            req_q, req_d, we_q, we_d, io_q, io_d;
  logic            drv_q, drv_d, err_q, err_d, abort_q, abort_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [AD_W-1:0] wdata_q, wdata_d, ad_out_q, ad_out_d;
  logic            oe_fall, we_fall, we_rise;

  ext_bus_target_bus_sync #(.W(3), .STAGES(SYNC_STAGES), .RST_VAL(STROBES_IDLE)) u_sync_strb (
    .clk (clk), .rst_n (rst_n),
    .d   ({bus.ale_n, bus.oe_n, bus.we_n}),
    .q   (strb_s)
  );

  // Data rides through the same depth as the strobes so the two stay aligned.
  ext_bus_target_bus_sync #(.W($bits(bus_data_t)), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_data (
    .clk (clk), .rst_n (rst_n),
    .d   ({bus.pio, bus.adr_hi, bus.ad_in}),
    .q   (data_s)
  );

  assign oe_fall = oe_p & ~strb_s.oe_n;
  assign we_fall = we_p & ~strb_s.we_n;
  assign we_rise = ~we_p & strb_s.we_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      oe_p     <= 1'b1;
      we_p     <= 1'b1;
      ad_d     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      ad_out_q <= '0;
      drv_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      oe_p     <= strb_s.oe_n;
      we_p     <= strb_s.we_n;
      ad_d     <= data_s.ad;
      req_q    <= req_d;
      we_q     <= we_d;
      io_q     <= io_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      ad_out_q <= ad_out_d;
      drv_q    <= drv_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets its default before the case so no path infers a latch.
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    io_d     = io_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    ad_out_d = ad_out_q;
    drv_d    = drv_q;
    abort_d  = abort_q;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!strb_s.ale_n)          state_d = ST_ADDR;
        else if (oe_fall || we_fall) err_d  = 1'b1;
      end
      ST_ADDR: begin
        if (!strb_s.ale_n) begin
          adr_d = ADDR_W'({data_s.adr_hi, data_s.ad});
          io_d  = data_s.pio;
        end else begin
          state_d = ST_ARMED;
        end
      end
      // Level-sensitive so a strobe that fell while ale_n was still in the
      // synchronizer is not missed.
      ST_ARMED: begin
        if (!strb_s.oe_n && !strb_s.we_n) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else if (!strb_s.oe_n) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = ST_RD_REQ;
        end else if (!strb_s.we_n) begin
          state_d = ST_WR_WAIT;
        end else if (!strb_s.ale_n) begin
          state_d = ST_ADDR;
        end
      end
      ST_RD_REQ: begin
        if (strb_s.oe_n) abort_d = 1'b1;
        if (bus.tgt_ack) begin
          req_d   = 1'b0;
          abort_d = 1'b0;
          if (abort_q) begin
            err_d   = 1'b1;
            state_d = strb_s.ale_n ? ST_IDLE : ST_ADDR;
          end else begin
            ad_out_d = bus.tgt_rdata;
            drv_d    = 1'b1;
            state_d  = ST_RD_DRIVE;
          end
        end
      end
      ST_RD_DRIVE: begin
        if (strb_s.oe_n) begin
          drv_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (we_rise) begin
          wdata_d = ad_d;
          we_d    = 1'b1;
          req_d   = 1'b1;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (bus.tgt_ack) begin
          req_d   = 1'b0;
          state_d = strb_s.ale_n ? ST_IDLE : ST_ADDR;
        end
      end
      ST_DRAIN: begin
        if (strb_s.oe_n && strb_s.we_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad drive is gated by the raw strobe so it releases the instant oe_n rises.
  assign bus.ad_oe     = drv_q & ~bus.oe_n;
  assign bus.ad_out    = ad_out_q;
  assign bus.tgt_req   = req_q;
  assign bus.tgt_we    = we_q;
  assign bus.tgt_io    = io_q;
  assign bus.tgt_adr   = adr_q;
  assign bus.tgt_wdata = wdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ext_bus_target.sv
// Randomised bench for ext_bus_target: a transaction-level model predicts the
// internal requests, error pulses and read data seen for each bus cycle.
module tb_ext_bus_target;
  import ext_bus_target_pkg::*;

  typedef struct packed {
    logic [19:0] adr;
    logic        io;
    logic        we;
    logic [15:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ext_bus_target_if bus ();

  ext_bus_target #(.SYNC_STAGES(2), .ADDR_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int oe_cnt  = 0;
  int drop_viol = 0;
  int ack_dly = 2;
  logic [15:0] rd_val = 16'h0;
  req_t obs_q[$];
  req_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observer: records each new request, counts err pulses and pad-drive cycles.
  initial begin : monitor
    logic req_prev;
    logic ack_edge;
    req_t r;
    req_prev = 1'b0;
    forever begin
      @(posedge clk);
      ack_edge = bus.tgt_ack;
      #1;
      if (bus.tgt_req && !req_prev) begin
        r.adr   = bus.tgt_adr;
        r.io    = bus.tgt_io;
        r.we    = bus.tgt_we;
        r.wdata = bus.tgt_wdata;
        obs_q.push_back(r);
      end
      if (req_prev && !bus.tgt_req && rst_n && !ack_edge) drop_viol++;
      if (bus.err)   err_cnt++;
      if (bus.ad_oe) oe_cnt++;
      req_prev = bus.tgt_req;
    end
  end

  // Internal target: acks ack_dly cycles after a request, abandons on reset.
  initial begin : responder
    bit live;
    bus.tgt_ack   = 1'b0;
    bus.tgt_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.tgt_req && rst_n) begin
        live = 1'b1;
        for (int i = 1; i < ack_dly; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            live = 1'b0;
            break;
          end
        end
        if (live) begin
          bus.tgt_ack   = 1'b1;
          bus.tgt_rdata = rd_val;
          @(negedge clk);
          bus.tgt_ack   = 1'b0;
          bus.tgt_rdata = ~rd_val;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_req(input logic [19:0] adr, input logic io, input logic we,
                            input logic [15:0] wdata);
    req_t e;
    e.adr   = adr;
    e.io    = io;
    e.we    = we;
    e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Entered and left on a negedge; pins are scrambled once ale_n rises.
  task automatic addr_phase(input logic [19:0] adr, input logic io);
    bus.ad_in  = adr[15:0];
    bus.adr_hi = adr[19:16];
    bus.pio    = io;
    bus.ale_n  = 1'b0;
    repeat (3) @(negedge clk);
    bus.ale_n  = 1'b1;
    bus.ad_in  = 16'($urandom);
    bus.adr_hi = 4'($urandom);
    bus.pio    = ~io;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_txn(input logic [19:0] adr, input logic io, input logic [15:0] data,
                          input int oe_len, input int dly, input int gap, input bit expect_data);
    rd_val  = data;
    ack_dly = dly;
    addr_phase(adr, io);
    expect_req(adr, io, 1'b0, 16'h0);
    bus.oe_n = 1'b0;
    repeat (oe_len) @(negedge clk);
    if (expect_data) begin
      check("rd_ad_oe", 32'(bus.ad_oe), 32'd1);
      check("rd_ad_out", 32'(bus.ad_out), 32'(data));
    end
    bus.oe_n = 1'b1;
    #1;
    check("rd_oe_release", 32'(bus.ad_oe), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic write_txn(input logic [19:0] adr, input logic io, input logic [15:0] data,
                           input int we_len, input int dly, input int gap);
    ack_dly = dly;
    addr_phase(adr, io);
    expect_req(adr, io, 1'b1, data);
    bus.ad_in = data;
    bus.we_n  = 1'b0;
    repeat (we_len) @(negedge clk);
    bus.we_n  = 1'b1;
    bus.ad_in = ~data;
    repeat (gap) @(negedge clk);
  endtask

  task automatic compare_reqs(input string tag);
    req_t o;
    req_t e;
    check({tag, "_nreq"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_adr"}, 32'(o.adr), 32'(e.adr));
      check({tag, "_io"},  32'(o.io),  32'(e.io));
      check({tag, "_we"},  32'(o.we),  32'(e.we));
      if (e.we) check({tag, "_wdata"}, 32'(o.wdata), 32'(e.wdata));
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin : main
    int   oe0;
    bit   hit;
    bit   kind;
    int   dly;
    logic [19:0] radr;
    logic [15:0] rdat;

    bus.ad_in  = 16'h0;
    bus.adr_hi = 4'h0;
    bus.pio    = 1'b0;
    bus.ale_n  = 1'b1;
    bus.oe_n   = 1'b1;
    bus.we_n   = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req",   32'(bus.tgt_req),   32'd0);
    check("rst_we",    32'(bus.tgt_we),    32'd0);
    check("rst_io",    32'(bus.tgt_io),    32'd0);
    check("rst_adr",   32'(bus.tgt_adr),   32'd0);
    check("rst_wdata", 32'(bus.tgt_wdata), 32'd0);
    check("rst_ad_out", 32'(bus.ad_out),   32'd0);
    check("rst_ad_oe", 32'(bus.ad_oe),     32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    rst_n = 1'b1;
    idle(3);

    // Memory read with a 2-cycle ack.
    read_txn(20'h31234, 1'b0, 16'hBEEF, 12, 2, 4, 1'b1);
    compare_reqs("mem_rd");

    // IO write: never drives the pads.
    oe0 = oe_cnt;
    write_txn(20'h000A5, 1'b1, 16'h5A5A, 6, 2, 8);
    compare_reqs("io_wr");
    check("io_wr_no_ad_oe", 32'(oe_cnt), 32'(oe0));

    // Read strobe released long before the ack.
    oe0 = oe_cnt;
    exp_err++;
    read_txn(20'h12345, 1'b0, 16'h1111, 3, 8, 14, 1'b0);
    compare_reqs("early_rel");
    check("early_rel_no_ad_oe", 32'(oe_cnt), 32'(oe0));

    // Both strobes together: no request, then DRAIN until both are high.
    addr_phase(20'h0ABCD, 1'b0);
    bus.oe_n = 1'b0;
    bus.we_n = 1'b0;
    idle(6);
    exp_err++;
    compare_reqs("contend");
    bus.oe_n = 1'b1;
    idle(4);
    bus.oe_n = 1'b0;
    idle(4);
    compare_reqs("drain_hold");
    bus.oe_n = 1'b1;
    bus.we_n = 1'b1;
    idle(4);
    bus.oe_n = 1'b0;
    idle(4);
    bus.oe_n = 1'b1;
    idle(4);
    exp_err++;
    compare_reqs("idle_oe");
    bus.we_n = 1'b0;
    idle(4);
    bus.we_n = 1'b1;
    idle(4);
    exp_err++;
    compare_reqs("idle_we");

    // Reset while the read request is outstanding.
    ack_dly = 30;
    rd_val  = 16'h9999;
    addr_phase(20'h0F00F, 1'b0);
    expect_req(20'h0F00F, 1'b0, 1'b0, 16'h0);
    bus.oe_n = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.tgt_req) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_mid_req_seen", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req",   32'(bus.tgt_req), 32'd0);
    check("rst_mid_ad_oe", 32'(bus.ad_oe),   32'd0);
    check("rst_mid_err",   32'(bus.err),     32'd0);
    compare_reqs("rst_mid");
    @(negedge clk);
    bus.oe_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    read_txn(20'h7C0DE, 1'b1, 16'hC0DE, 10, 3, 4, 1'b1);
    compare_reqs("post_rst_rd");

    // Back-to-back read then write with no idle gap.
    read_txn(20'h00010, 1'b0, 16'hA001, 10, 2, 0, 1'b1);
    write_txn(20'h00011, 1'b0, 16'hB002, 5, 2, 8);
    compare_reqs("b2b");

    // Random mix of reads and writes.
    for (int n = 0; n < 16; n++) begin
      kind = 1'($urandom);
      radr = 20'($urandom);
      rdat = 16'($urandom);
      dly  = int'($urandom_range(1, 4));
      if (kind)
        read_txn(radr, 1'($urandom), rdat, dly + 6 + int'($urandom_range(0, 3)), dly,
                 int'($urandom_range(0, 3)), 1'b1);
      else
        write_txn(radr, 1'($urandom), rdat, int'($urandom_range(2, 6)), dly, dly + 6);
      compare_reqs("rnd");
    end

    idle(5);
    check("req_drop_wo_ack", 32'(drop_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
